// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: assembles 32-bit instructions from DATA_WIDTH-bit memory beats and presents them with their pc.
// Define IFU_PREFETCH_EN to add a second instruction buffer so fetching overlaps a stalled consumer.
module instr_fetch_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);
  localparam int N = 32 / DATA_WIDTH;
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, pc_q, pc_d, wpc;
  logic [CW-1:0] beat_q, beat_d;
  logic [31:0] asm_q, asm_d, instr_q, instr_d, word;
  logic valid_q, valid_d, fire, last, hs;
`ifdef IFU_PREFETCH_EN
  logic [31:0] nxt_q, nxt_d;
  logic [ADDR_WIDTH-1:0] nxt_pc_q, nxt_pc_d;
  logic nxt_v_q, nxt_v_d;
  assign mem_req = (state_q == FETCH) | ((state_q == HOLD) & ~nxt_v_q);
`else
  assign mem_req = state_q == FETCH;
`endif
  assign mem_addr = addr_q;
  assign instr = instr_q;
  assign pc = pc_q;
  assign instr_valid = valid_q;
  assign fire = mem_req & mem_ack & ~redirect;
  assign last = fire & (beat_q == CW'(N - 1));
  assign hs = valid_q & instr_ready;
  // the final beat's address has already been issued, so beat 0 sits (N-1) beats back
  assign wpc = addr_q - ADDR_WIDTH'((N - 1) * BW);
  always_comb begin
    word = asm_q;
    word[beat_q * DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    beat_d = beat_q;
    asm_d = asm_q;
    instr_d = instr_q;
    pc_d = pc_q;
    valid_d = valid_q;
`ifdef IFU_PREFETCH_EN
    nxt_d = nxt_q;
    nxt_pc_d = nxt_pc_q;
    nxt_v_d = nxt_v_q;
`endif
    if (redirect) begin
      state_d = FETCH;
      addr_d = redirect_pc & ~ADDR_WIDTH'(3);
      beat_d = '0;
      valid_d = 1'b0;
`ifdef IFU_PREFETCH_EN
      nxt_v_d = 1'b0;
`endif
    end else if (state_q == IDLE) begin
      state_d = FETCH;
    end else begin
      if (fire) begin
        asm_d = word;
        beat_d = last ? '0 : beat_q + CW'(1);
        addr_d = addr_q + ADDR_WIDTH'(BW);
      end
`ifdef IFU_PREFETCH_EN
      if (hs) begin
        valid_d = nxt_v_q;
        instr_d = nxt_q;
        pc_d = nxt_pc_q;
        nxt_v_d = 1'b0;
      end
      if (last && !valid_d) begin
        instr_d = word;
        pc_d = wpc;
        valid_d = 1'b1;
      end else if (last) begin
        nxt_d = word;
        nxt_pc_d = wpc;
        nxt_v_d = 1'b1;
      end
`else
      if (hs) valid_d = 1'b0;
      if (last) begin
        instr_d = word;
        pc_d = wpc;
        valid_d = 1'b1;
      end
`endif
      state_d = valid_d ? HOLD : FETCH;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= RESET_PC;
      beat_q <= '0;
      asm_q <= '0;
      instr_q <= '0;
      pc_q <= RESET_PC;
      valid_q <= 1'b0;
`ifdef IFU_PREFETCH_EN
      nxt_q <= '0;
      nxt_pc_q <= '0;
      nxt_v_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      beat_q <= beat_d;
      asm_q <= asm_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
`ifdef IFU_PREFETCH_EN
      nxt_q <= nxt_d;
      nxt_pc_q <= nxt_pc_d;
      nxt_v_q <= nxt_v_d;
`endif
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 8: memory beat width in bits; legal values 8, 16, 32.
REQ-002 Parameter ADDR_WIDTH, default 8: byte-address width.
REQ-003 Parameter RESET_PC, default 0: first instruction fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mem_req  output  1  memory read request, held until mem_ack.
REQ-007 mem_addr  output  ADDR_WIDTH  byte address of current beat, stable while mem_req=1.
REQ-008 mem_ack  input  1  beat accepted; mem_rdata valid in the same cycle.
REQ-009 mem_rdata  input  DATA_WIDTH  read data beat.
REQ-010 instr  output  32  assembled instruction word.
REQ-011 instr_valid  output  1  instr and pc valid.
REQ-012 instr_ready  input  1  consumer accepts instr when instr_valid=1.
REQ-013 pc  output  ADDR_WIDTH  byte address of the instruction on instr.
REQ-014 redirect  input  1  branch/jump: discard in-flight work, refetch from redirect_pc.
REQ-015 redirect_pc  input  ADDR_WIDTH  new fetch address; bits [1:0] ignored, treated as 00.

Function
REQ-016 Beats per instruction N = 32/DATA_WIDTH; beat k (k=0..N-1) SHALL be written to instr[k*DATA_WIDTH +: DATA_WIDTH].
REQ-017 States: IDLE, FETCH, HOLD; IDLE SHALL advance to FETCH unconditionally on the next edge.
REQ-018 mem_req SHALL be 1 exactly when in FETCH (and, with prefetch, when the prefetch buffer is empty); mem_addr SHALL not change while mem_req=1 and mem_ack=0.
REQ-019 On each mem_ack in FETCH: capture beat, increment beat counter, advance fetch address by DATA_WIDTH/8, modulo 2^ADDR_WIDTH (wrap to 0).
REQ-020 On the ack of beat N-1: next state HOLD, instr_valid=1 from the following cycle, pc = address of beat 0, beat counter = 0.
REQ-021 In HOLD, instr/pc/instr_valid SHALL stay stable until instr_valid&instr_ready; that edge returns to FETCH at the already-advanced fetch address.
REQ-022 redirect SHALL have highest priority in every state: partial beats discarded, beat counter=0, fetch address=redirect_pc&~3, state FETCH, instr_valid=0 next cycle; a mem_ack in the same cycle is ignored.
REQ-023 redirect together with instr_valid&instr_ready: the presented instruction counts as consumed, then the redirect applies.
REQ-024 mem_ack while mem_req=0 SHALL be ignored.
REQ-025 Throughput without prefetch, DATA_WIDTH=32, mem_ack and instr_ready tied 1: one instruction per 2 cycles.

Reset
REQ-026 While rst_n=0: state IDLE, mem_req=0, instr_valid=0, instr=0, pc=RESET_PC, fetch address=RESET_PC, beat counter=0.
REQ-027 rst_n asserted mid-fetch or mid-HOLD SHALL abandon all work immediately (asynchronously) with no further mem_req.

Configuration
REQ-028 Macro IFU_PREFETCH_EN compiled in: a second 32-bit+pc buffer SHALL let FETCH continue while HOLD presents an instruction; on handshake the prefetched word is promoted on the same edge (instr_valid stays 1); mem_req drops when both buffers are full; redirect flushes both.
REQ-029 With IFU_PREFETCH_EN, DATA_WIDTH=32, mem_ack and instr_ready tied 1: one instruction per cycle after the first.
REQ-030 Without IFU_PREFETCH_EN: single buffer, behaviour exactly REQ-016..REQ-025; no prefetch storage synthesised.

Verification
REQ-031 DATA_WIDTH=8, RESET_PC=0, memory bytes 0x00..0x03 = 11,22,33,44, ack every cycle -> mem_addr 0,1,2,3; instr=0x44332211, pc=0, instr_valid=1.
REQ-032 DATA_WIDTH=16, instr_ready=0 for 5 cycles -> instr/pc constant, mem_req=0 (no prefetch) during stall; after ready, mem_addr=4.
REQ-033 DATA_WIDTH=8, redirect with redirect_pc=0x43 after beat 2 acked -> next mem_addr=0x40, first valid instr has pc=0x40 built from bytes 0x40..0x43.
REQ-034 ADDR_WIDTH=8, DATA_WIDTH=32, RESET_PC=0xFC -> first instr pc=0xFC, next mem_addr=0x00.
REQ-035 rst_n low during beat 1 of a fetch -> mem_req and instr_valid 0 same cycle; after release, first mem_addr=RESET_PC.
REQ-036 IFU_PREFETCH_EN, DATA_WIDTH=32, ack and ready tied 1, 8 sequential words -> 8 instructions on 8 consecutive cycles, pc 0,4,...,28.
